mem_arbiter: RTL and testbench

Sequences the single external SRAM-like memory port and shares it between the fetch bus (ibus) and the memory-stage data bus (dbus, driven by the mm stage's memory controller). Keeps at most one transaction outstanding, gives dbus priority, and returns per-requester stall and read data to the pipeline. On an exception flush it discards any read result still in flight, without violating the downstream handshake.

---
 rtl/mem_arbiter_pkg.sv | 37 +++
 rtl/mem_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter.
//
// Purpose: bus widths, the arbiter FSM state encoding, the owner encoding
// (which requester holds the downstream port) and the latched downstream
// command record.
//
// Contents:
//   W_ADDR, W_DATA   address / data widths (32 bits each)
//   arb_state_e      IDLE / ADDR / DATA arbiter states
//   owner_e          OWN_I (fetch bus) / OWN_D (data bus)
//   mem_cmd_t        fields presented on the downstream port for one access
package mem_arbiter_pkg;

  localparam int W_ADDR = 32;
  localparam int W_DATA = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Everything that must stay stable on the downstream port from the grant
  // until the address phase is accepted.
  typedef struct packed {
    logic              wr;
    logic [3:0]        wstrb;
    logic [W_ADDR-1:0] addr;
    logic [W_DATA-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter.sv
// Memory-port arbiter between the fetch bus (ibus) and the data bus (dbus).
//
// Purpose: owns the single SRAM-like downstream port, keeps at most one
// access outstanding, serves dbus before ibus, and hands completion status
// (stall) and read data back to each requester. An exception flush turns an
// in-flight read into a discarded one; the downstream handshake is always
// run to completion.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   flush, adv                      pipeline exception / whole-pipe advance
//   ibus_en, ibus_addr              fetch request
//   ibus_rdata, ibus_stall          fetch result and stall
//   dbus_en, dbus_we, dbus_addr,
//   dbus_wdata                      data request (we == 0 means read)
//   dbus_rdata, dbus_stall          load result and stall
//   mem_req, mem_wr, mem_wstrb,
//   mem_addr, mem_wdata             downstream request
//   mem_addr_ok, mem_data_ok,
//   mem_rdata                       downstream acceptance / completion
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              adv,

  input  logic              ibus_en,
  input  logic [W_ADDR-1:0] ibus_addr,
  output logic [W_DATA-1:0] ibus_rdata,
  output logic              ibus_stall,

  input  logic              dbus_en,
  input  logic [3:0]        dbus_we,
  input  logic [W_ADDR-1:0] dbus_addr,
  input  logic [W_DATA-1:0] dbus_wdata,
  output logic [W_DATA-1:0] dbus_rdata,
  output logic              dbus_stall,

  output logic              mem_req,
  output logic              mem_wr,
  output logic [3:0]        mem_wstrb,
  output logic [W_ADDR-1:0] mem_addr,
  output logic [W_DATA-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [W_DATA-1:0] mem_rdata
);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  mem_cmd_t          cmd_q, cmd_d;
  logic              discard_q, discard_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;
  logic [W_DATA-1:0] ibus_rdata_q, ibus_rdata_d;
  logic [W_DATA-1:0] dbus_rdata_q, dbus_rdata_d;

  logic i_pend;
  logic d_pend;
  logic flush_kills;
  logic drop;
  logic complete;
  logic i_set;
  logic d_set;

  // A requester is pending while enabled and its current access has not yet
  // been completed for this instruction.
  assign i_pend = ibus_en & ~i_done_q;
  assign d_pend = dbus_en & ~d_done_q;

  // A flush cancels the result of fetches and loads; stores keep going so
  // memory sees them exactly once. The current-cycle flush is folded in so a
  // flush coinciding with data_ok also throws the read result away.
  assign flush_kills = flush & ((owner_q == OWN_I) | ~cmd_q.wr);
  assign drop        = discard_q | flush_kills;
  assign complete    = (state_q == ST_DATA) & mem_data_ok;
  assign i_set       = complete & ~drop & (owner_q == OWN_I);
  assign d_set       = complete & ~drop & (owner_q == OWN_D);

  // Arbiter FSM: grant in IDLE (dbus first), hold the request in ADDR until
  // accepted, wait for the response in DATA. Command fields and read data
  // registers only change at grant / completion respectively.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cmd_d        = cmd_q;
    discard_d    = discard_q;
    ibus_rdata_d = ibus_rdata_q;
    dbus_rdata_d = dbus_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (!flush) begin
          if (d_pend) begin
            owner_d     = OWN_D;
            cmd_d.wr    = |dbus_we;
            cmd_d.wstrb = dbus_we;
            cmd_d.addr  = dbus_addr;
            cmd_d.wdata = dbus_wdata;
            state_d     = ST_ADDR;
          end else if (i_pend) begin
            owner_d     = OWN_I;
            cmd_d.wr    = 1'b0;
            cmd_d.wstrb = 4'b0000;
            cmd_d.addr  = ibus_addr;
            cmd_d.wdata = '0;
            state_d     = ST_ADDR;
          end
        end
      end

      ST_ADDR: begin
        if (flush_kills) begin
          discard_d = 1'b1;
        end
        if (mem_addr_ok) begin
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (flush_kills) begin
          discard_d = 1'b1;
        end
        if (mem_data_ok) begin
          state_d   = ST_IDLE;
          discard_d = 1'b0;
          if (!drop) begin
            if (owner_q == OWN_D) begin
              dbus_rdata_d = mem_rdata;
            end else begin
              ibus_rdata_d = mem_rdata;
            end
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        discard_d = 1'b0;
      end
    endcase
  end

  // Done flags are sticky until the pipeline moves on. A completion in the
  // same cycle as adv belongs to the next instruction, so set beats adv;
  // flush always wins.
  always_comb begin
    i_done_d = i_done_q;
    d_done_d = d_done_q;

    if (i_set) begin
      i_done_d = ~flush;
    end else if (adv || flush) begin
      i_done_d = 1'b0;
    end

    if (d_set) begin
      d_done_d = ~flush;
    end else if (adv || flush) begin
      d_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_I;
      cmd_q        <= '0;
      discard_q    <= 1'b0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      ibus_rdata_q <= '0;
      dbus_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      cmd_q        <= cmd_d;
      discard_q    <= discard_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
      ibus_rdata_q <= ibus_rdata_d;
      dbus_rdata_q <= dbus_rdata_d;
    end
  end

  assign mem_req    = (state_q == ST_ADDR);
  assign mem_wr     = cmd_q.wr;
  assign mem_wstrb  = cmd_q.wstrb;
  assign mem_addr   = cmd_q.addr;
  assign mem_wdata  = cmd_q.wdata;

  assign ibus_stall = ibus_en & ~i_done_q;
  assign dbus_stall = dbus_en & ~d_done_q;
  assign ibus_rdata = ibus_rdata_q;
  assign dbus_rdata = dbus_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter.
//
// Each vector is one clock cycle: inputs are driven after the falling edge,
// outputs are compared shortly afterwards (well away from the rising edge),
// and the rising edge then advances the design. The downstream memory is
// played directly by the vectors through mem_addr_ok / mem_data_ok.
module tb_mem_arbiter;

  import mem_arbiter_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              adv;
  logic              ibus_en;
  logic [W_ADDR-1:0] ibus_addr;
  logic [W_DATA-1:0] ibus_rdata;
  logic              ibus_stall;
  logic              dbus_en;
  logic [3:0]        dbus_we;
  logic [W_ADDR-1:0] dbus_addr;
  logic [W_DATA-1:0] dbus_wdata;
  logic [W_DATA-1:0] dbus_rdata;
  logic              dbus_stall;
  logic              mem_req;
  logic              mem_wr;
  logic [3:0]        mem_wstrb;
  logic [W_ADDR-1:0] mem_addr;
  logic [W_DATA-1:0] mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [W_DATA-1:0] mem_rdata;

  int vectors_applied = 0;
  int miscompares     = 0;
  int checks_made     = 0;

  // ctl  = {rst_n, flush, adv, ibus_en, dbus_en, mem_addr_ok, mem_data_ok}
  // eflg = {ibus_stall, dbus_stall, mem_req, mem_wr}
  typedef struct {
    string       nm;
    logic [6:0]  ctl;
    logic [31:0] iaddr;
    logic [3:0]  dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] mrd;
    logic [3:0]  eflg;
    logic [3:0]  ews;
    logic [31:0] eaddr;
    logic [31:0] ewd;
    logic [31:0] eir;
    logic [31:0] edr;
  } vec_t;

  vec_t vec_table[$];

  mem_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .adv         (adv),
    .ibus_en     (ibus_en),
    .ibus_addr   (ibus_addr),
    .ibus_rdata  (ibus_rdata),
    .ibus_stall  (ibus_stall),
    .dbus_en     (dbus_en),
    .dbus_we     (dbus_we),
    .dbus_addr   (dbus_addr),
    .dbus_wdata  (dbus_wdata),
    .dbus_rdata  (dbus_rdata),
    .dbus_stall  (dbus_stall),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_wstrb   (mem_wstrb),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_addr_ok (mem_addr_ok),
    .mem_data_ok (mem_data_ok),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(string nm, logic [6:0] ctl, logic [31:0] iaddr,
                              logic [3:0] dwe, logic [31:0] daddr, logic [31:0] dwdata,
                              logic [31:0] mrd, logic [3:0] eflg, logic [3:0] ews,
                              logic [31:0] eaddr, logic [31:0] ewd,
                              logic [31:0] eir, logic [31:0] edr);
    vec_t v;
    v.nm = nm; v.ctl = ctl; v.iaddr = iaddr; v.dwe = dwe; v.daddr = daddr;
    v.dwdata = dwdata; v.mrd = mrd; v.eflg = eflg; v.ews = ews;
    v.eaddr = eaddr; v.ewd = ewd; v.eir = eir; v.edr = edr;
    return v;
  endfunction

  task automatic checkField(input string nm, input string fld,
                            input logic [31:0] act, input logic [31:0] exp);
    checks_made++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s.%s got %h expected %h", nm, fld, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    {rst_n, flush, adv, ibus_en, dbus_en, mem_addr_ok, mem_data_ok} = v.ctl;
    ibus_addr  = v.iaddr;
    dbus_we    = v.dwe;
    dbus_addr  = v.daddr;
    dbus_wdata = v.dwdata;
    mem_rdata  = v.mrd;
    vectors_applied++;
  endtask

  // Compare every observable output mid-way through the low clock phase.
  task automatic checkOutput(input vec_t v);
    #2;
    checkField(v.nm, "ibus_stall", {31'd0, ibus_stall}, {31'd0, v.eflg[3]});
    checkField(v.nm, "dbus_stall", {31'd0, dbus_stall}, {31'd0, v.eflg[2]});
    checkField(v.nm, "mem_req",    {31'd0, mem_req},    {31'd0, v.eflg[1]});
    checkField(v.nm, "mem_wr",     {31'd0, mem_wr},     {31'd0, v.eflg[0]});
    checkField(v.nm, "mem_wstrb",  {28'd0, mem_wstrb},  {28'd0, v.ews});
    checkField(v.nm, "mem_addr",   mem_addr,   v.eaddr);
    checkField(v.nm, "mem_wdata",  mem_wdata,  v.ewd);
    checkField(v.nm, "ibus_rdata", ibus_rdata, v.eir);
    checkField(v.nm, "dbus_rdata", dbus_rdata, v.edr);
  endtask

  task automatic runVec(input vec_t v);
    applyStimulus(v);
    checkOutput(v);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; adv = 1'b0;
    ibus_en = 1'b0; ibus_addr = '0;
    dbus_en = 1'b0; dbus_we = '0; dbus_addr = '0; dbus_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);

    // Reset values, single fetch at minimum latency.
    vec_table.push_back(mk("reset",      7'b0_0_0_1_1_0_0, 32'h0,        4'h0, 32'h0, 32'h0, 32'h0,        4'b1100, 4'h0, 32'h0,        32'h0, 32'h0,        32'h0));
    vec_table.push_back(mk("fetch_c0",   7'b1_0_0_1_0_0_0, 32'hBFC00000, 4'h0, 32'h0, 32'h0, 32'h0,        4'b1000, 4'h0, 32'h0,        32'h0, 32'h0,        32'h0));
    vec_table.push_back(mk("fetch_c1",   7'b1_0_0_1_0_1_0, 32'hBFC00000, 4'h0, 32'h0, 32'h0, 32'h0,        4'b1010, 4'h0, 32'hBFC00000, 32'h0, 32'h0,        32'h0));
    vec_table.push_back(mk("fetch_c2",   7'b1_0_0_1_0_0_1, 32'hBFC00000, 4'h0, 32'h0, 32'h0, 32'h24080001, 4'b1000, 4'h0, 32'hBFC00000, 32'h0, 32'h0,        32'h0));
    vec_table.push_back(mk("fetch_c3",   7'b1_0_1_1_0_0_0, 32'hBFC00000, 4'h0, 32'h0, 32'h0, 32'h0,        4'b0000, 4'h0, 32'hBFC00000, 32'h0, 32'h24080001, 32'h0));
    vec_table.push_back(mk("fetch_idle", 7'b1_0_0_0_0_0_0, 32'h0,        4'h0, 32'h0, 32'h0, 32'h0,        4'b0000, 4'h0, 32'hBFC00000, 32'h0, 32'h24080001, 32'h0));
    // Contention: store wins, fetch follows after one IDLE cycle.
    vec_table.push_back(mk("cont_c0",    7'b1_0_0_1_1_0_0, 32'hBFC00004, 4'h3, 32'h80000010, 32'hDEADBEEF, 32'h0,        4'b1100, 4'h0, 32'hBFC00000, 32'h0,        32'h24080001, 32'h0));
    vec_table.push_back(mk("cont_c1",    7'b1_0_0_1_1_1_0, 32'hBFC00004, 4'h3, 32'h80000010, 32'hDEADBEEF, 32'h0,        4'b1111, 4'h3, 32'h80000010, 32'hDEADBEEF, 32'h24080001, 32'h0));
    vec_table.push_back(mk("cont_c2",    7'b1_0_0_1_1_0_1, 32'hBFC00004, 4'h3, 32'h80000010, 32'hDEADBEEF, 32'h11111111, 4'b1101, 4'h3, 32'h80000010, 32'hDEADBEEF, 32'h24080001, 32'h0));
    vec_table.push_back(mk("cont_c3",    7'b1_0_0_1_1_0_0, 32'hBFC00004, 4'h3, 32'h80000010, 32'hDEADBEEF, 32'h0,        4'b1001, 4'h3, 32'h80000010, 32'hDEADBEEF, 32'h24080001, 32'h11111111));
    vec_table.push_back(mk("cont_c4",    7'b1_0_0_1_1_0_0, 32'hBFC00004, 4'h3, 32'h80000010, 32'hDEADBEEF, 32'h0,        4'b1010, 4'h0, 32'hBFC00004, 32'h0,        32'h24080001, 32'h11111111));
    vec_table.push_back(mk("cont_c5",    7'b1_0_0_1_1_1_0, 32'hBFC00004, 4'h3, 32'h80000010, 32'hDEADBEEF, 32'h0,        4'b1010, 4'h0, 32'hBFC00004, 32'h0,        32'h24080001, 32'h11111111));
    vec_table.push_back(mk("cont_c6",    7'b1_0_0_1_1_0_1, 32'hBFC00004, 4'h3, 32'h80000010, 32'hDEADBEEF, 32'h8C020004, 4'b1000, 4'h0, 32'hBFC00004, 32'h0,        32'h24080001, 32'h11111111));
    vec_table.push_back(mk("cont_adv",   7'b1_0_1_1_1_0_0, 32'hBFC00004, 4'h3, 32'h80000010, 32'hDEADBEEF, 32'h0,        4'b0000, 4'h0, 32'hBFC00004, 32'h0,        32'h8C020004, 32'h11111111));
    // Load whose data_ok coincides with adv: done flag still set and held.
    vec_table.push_back(mk("load_c0",    7'b1_0_0_0_1_0_0, 32'h0, 4'h0, 32'h80000020, 32'h0, 32'h0,        4'b0100, 4'h0, 32'hBFC00004, 32'h0, 32'h8C020004, 32'h11111111));
    vec_table.push_back(mk("load_c1",    7'b1_0_0_0_1_1_0, 32'h0, 4'h0, 32'h80000020, 32'h0, 32'h0,        4'b0110, 4'h0, 32'h80000020, 32'h0, 32'h8C020004, 32'h11111111));
    vec_table.push_back(mk("load_c2adv", 7'b1_0_1_0_1_0_1, 32'h0, 4'h0, 32'h80000020, 32'h0, 32'hCAFEF00D, 4'b0100, 4'h0, 32'h80000020, 32'h0, 32'h8C020004, 32'h11111111));
    vec_table.push_back(mk("load_held",  7'b1_0_0_0_1_0_0, 32'h0, 4'h0, 32'h80000020, 32'h0, 32'h0,        4'b0000, 4'h0, 32'h80000020, 32'h0, 32'h8C020004, 32'hCAFEF00D));
    vec_table.push_back(mk("load_adv",   7'b1_0_1_0_1_0_0, 32'h0, 4'h0, 32'h80000020, 32'h0, 32'h0,        4'b0000, 4'h0, 32'h80000020, 32'h0, 32'h8C020004, 32'hCAFEF00D));
    vec_table.push_back(mk("load_idle",  7'b1_0_0_0_0_0_0, 32'h0, 4'h0, 32'h0,        32'h0, 32'h0,        4'b0000, 4'h0, 32'h80000020, 32'h0, 32'h8C020004, 32'hCAFEF00D));

    for (int k = 0; k < vec_table.size(); k++) begin
      runVec(vec_table[k]);
    end

    // Flush during ADDR of a fetch with addr_ok held off three cycles; the
    // read returns but is discarded, then a clean refetch updates rdata.
    // A flush in IDLE blocks the grant.
    runVec(mk("ffl_c0",  7'b1_0_0_1_0_0_0, 32'hBFC00100, 4'h0, 32'h0, 32'h0, 32'h0,        4'b1000, 4'h0, 32'h80000020, 32'h0, 32'h8C020004, 32'hCAFEF00D));
    runVec(mk("ffl_c1",  7'b1_1_0_1_0_0_0, 32'hBFC00100, 4'h0, 32'h0, 32'h0, 32'h0,        4'b1010, 4'h0, 32'hBFC00100, 32'h0, 32'h8C020004, 32'hCAFEF00D));
    runVec(mk("ffl_c2",  7'b1_0_0_1_0_0_1, 32'hBFC00100, 4'h0, 32'h0, 32'h0, 32'hBAD0BAD0, 4'b1010, 4'h0, 32'hBFC00100, 32'h0, 32'h8C020004, 32'hCAFEF00D));
    runVec(mk("ffl_c3",  7'b1_0_0_1_0_0_0, 32'hBFC00100, 4'h0, 32'h0, 32'h0, 32'h0,        4'b1010, 4'h0, 32'hBFC00100, 32'h0, 32'h8C020004, 32'hCAFEF00D));
    runVec(mk("ffl_c4",  7'b1_0_0_1_0_1_0, 32'hBFC00100, 4'h0, 32'h0, 32'h0, 32'h0,        4'b1010, 4'h0, 32'hBFC00100, 32'h0, 32'h8C020004, 32'hCAFEF00D));
    runVec(mk("ffl_c5",  7'b1_0_0_1_0_0_1, 32'hBFC00100, 4'h0, 32'h0, 32'h0, 32'h55555555, 4'b1000, 4'h0, 32'hBFC00100, 32'h0, 32'h8C020004, 32'hCAFEF00D));
    runVec(mk("ffl_c6",  7'b1_0_0_1_0_0_0, 32'hBFC00100, 4'h0, 32'h0, 32'h0, 32'h0,        4'b1000, 4'h0, 32'hBFC00100, 32'h0, 32'h8C020004, 32'hCAFEF00D));
    runVec(mk("ffl_c7",  7'b1_0_0_1_0_1_0, 32'hBFC00100, 4'h0, 32'h0, 32'h0, 32'h0,        4'b1010, 4'h0, 32'hBFC00100, 32'h0, 32'h8C020004, 32'hCAFEF00D));
    runVec(mk("ffl_c8",  7'b1_0_0_1_0_0_1, 32'hBFC00100, 4'h0, 32'h0, 32'h0, 32'h3C1DBFC0, 4'b1000, 4'h0, 32'hBFC00100, 32'h0, 32'h8C020004, 32'hCAFEF00D));
    runVec(mk("ffl_c9",  7'b1_0_1_1_0_0_0, 32'hBFC00100, 4'h0, 32'h0, 32'h0, 32'h0,        4'b0000, 4'h0, 32'hBFC00100, 32'h0, 32'h3C1DBFC0, 32'hCAFEF00D));
    runVec(mk("ffl_idl", 7'b1_1_0_1_0_0_0, 32'hBFC00100, 4'h0, 32'h0, 32'h0, 32'h0,        4'b1000, 4'h0, 32'hBFC00100, 32'h0, 32'h3C1DBFC0, 32'hCAFEF00D));
    runVec(mk("ffl_ng",  7'b1_0_0_0_0_0_0, 32'h0,        4'h0, 32'h0, 32'h0, 32'h0,        4'b0000, 4'h0, 32'hBFC00100, 32'h0, 32'h3C1DBFC0, 32'hCAFEF00D));

    // Flush during DATA of a store: it completes, d_done is set, and the
    // fetch waiting behind it is only granted from IDLE.
    runVec(mk("sfl_c0",  7'b1_0_0_0_1_0_0, 32'h0,        4'hF, 32'h80000040, 32'h12345678, 32'h0,        4'b0100, 4'h0, 32'hBFC00100, 32'h0,        32'h3C1DBFC0, 32'hCAFEF00D));
    runVec(mk("sfl_c1",  7'b1_0_0_0_1_1_0, 32'h0,        4'hF, 32'h80000040, 32'h12345678, 32'h0,        4'b0111, 4'hF, 32'h80000040, 32'h12345678, 32'h3C1DBFC0, 32'hCAFEF00D));
    runVec(mk("sfl_c2",  7'b1_1_0_1_1_0_0, 32'hBFC00200, 4'hF, 32'h80000040, 32'h12345678, 32'h0,        4'b1101, 4'hF, 32'h80000040, 32'h12345678, 32'h3C1DBFC0, 32'hCAFEF00D));
    runVec(mk("sfl_c3",  7'b1_0_0_1_1_0_1, 32'hBFC00200, 4'hF, 32'h80000040, 32'h12345678, 32'h77777777, 4'b1101, 4'hF, 32'h80000040, 32'h12345678, 32'h3C1DBFC0, 32'hCAFEF00D));
    runVec(mk("sfl_c4",  7'b1_0_0_1_1_0_0, 32'hBFC00200, 4'hF, 32'h80000040, 32'h12345678, 32'h0,        4'b1001, 4'hF, 32'h80000040, 32'h12345678, 32'h3C1DBFC0, 32'h77777777));
    runVec(mk("sfl_c5",  7'b1_0_0_1_1_1_0, 32'hBFC00200, 4'hF, 32'h80000040, 32'h12345678, 32'h0,        4'b1010, 4'h0, 32'hBFC00200, 32'h0,        32'h3C1DBFC0, 32'h77777777));

    // Reset asserted for one cycle while the fetch sits in DATA.
    runVec(mk("rst_c0",  7'b0_0_0_1_1_0_0, 32'hBFC00200, 4'hF, 32'h80000040, 32'h12345678, 32'h0, 4'b1000, 4'h0, 32'hBFC00200, 32'h0, 32'h3C1DBFC0, 32'h77777777));
    runVec(mk("rst_c1",  7'b1_1_0_1_1_0_0, 32'hBFC00200, 4'hF, 32'h80000040, 32'h12345678, 32'h0, 4'b1100, 4'h0, 32'h0,        32'h0, 32'h0,        32'h0));
    runVec(mk("rst_c2",  7'b1_0_0_0_0_0_1, 32'h0,        4'h0, 32'h0,        32'h0,        32'h0, 4'b0000, 4'h0, 32'h0,        32'h0, 32'h0,        32'h0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
